// File: rtl/instr_fetch_queue.sv
// Fetch unit: issues sequential imem requests under a credit limit and buffers {pc, instr}
// pairs in an in-order queue for decode; a redirect flushes the queue and squashes in-flight responses.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [31:0]                  imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [31:0]                  imem_rsp_data,
    output logic                         out_valid,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_instr,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         dbg_state
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned SW = 8;

    typedef enum logic {
        FETCH  = 1'b0,
        SQUASH = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [SW-1:0] squash_q, squash_d;
    logic [31:0]   last_pc_q, last_instr_q;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];

    logic          credit_ok;
    logic [31:0]   inflight;
    logic          req_fire;
    logic          rsp_push;
    logic          pop;
    logic [SW-1:0] squash_total;
    logic          unused_rpc_bits;

    // Handshakes: a transfer happens on a cycle where valid && ready; valid never waits on ready.
    // imem requests and decode pops both follow this; imem responses have no back-pressure.
    always_comb begin
        inflight  = 32'(count_q) + 32'(outst_q);
        credit_ok = (inflight < DEPTH) && (32'(outst_q) < MAX_OUT);
    end

    assign imem_req_valid  = !reset && !redirect && credit_ok;
    assign imem_req_addr   = fetch_pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign out_valid       = (count_q != '0);
    assign out_pc          = out_valid ? mem_pc[rd_ptr_q] : last_pc_q;
    assign out_instr       = out_valid ? mem_instr[rd_ptr_q] : last_instr_q;
    assign count           = count_q;
    assign pop             = out_valid && out_ready && !redirect;
    assign rsp_push        = imem_rsp_valid && (state_q == FETCH) && !redirect;
    assign squash_total    = squash_q + SW'(outst_q);
    assign dbg_state       = state_q;
    assign unused_rpc_bits = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        squash_d   = squash_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            outst_d    = '0;
            // Everything still in flight now belongs to a dead path, minus this cycle's response.
            squash_d   = (imem_rsp_valid && squash_total != '0) ? squash_total - SW'(1)
                                                                : squash_total;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid && state_q == SQUASH) begin
                squash_d = squash_q - SW'(1);
            end
            if (rsp_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(rsp_push) - CW'(pop);
            outst_d = outst_q + OW'(req_fire) - OW'(rsp_push);
        end
        state_d = (squash_d != '0) ? SQUASH : FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            outst_q      <= '0;
            squash_q     <= '0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            rsp_pc_q     <= rsp_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            squash_q     <= squash_d;
            last_pc_q    <= out_pc;
            last_instr_q <= out_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rsp_push) begin
            mem_pc[wr_ptr_q]    <= rsp_pc_q;
            mem_instr[wr_ptr_q] <= imem_rsp_data;
        end
    end

    // The credit check reserves a slot per request, so a kept response always finds room.
    assert property (@(posedge clk) disable iff (reset)
        !(rsp_push && !pop && count_q == CW'(DEPTH)));
    assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && squash_total == '0));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios against an epoch-tagged imem/queue model,
// checked every cycle, plus literal expectations for each scenario.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        reset, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        out_valid, out_ready, dbg_state;
    logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, out_pc, out_instr;
    logic [$clog2(DEPTH+1)-1:0] count;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .out_ready(out_ready), .count(count), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // stimulus knobs
    logic        drv_reset = 1'b1, drv_redirect = 1'b0, drv_oready = 1'b0, drv_rready = 1'b1;
    logic [31:0] drv_rpc = 32'h0;
    int          lat = 1;

    // model: decode-visible queue, last shown head, fetch pointer, epoch-tagged pending requests
    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];
    logic [31:0] m_last_pc = 32'h0, m_last_in = 32'h0, m_fetch_pc = 32'h0;
    int          epoch = 0;
    logic [31:0] pend_addr[$];
    int          pend_ep[$];
    int          pend_due[$];
    int          cyc = 0;
    bit          started = 1'b0;

    // samples of the DUT taken in the most recent cycle
    logic        s_req_valid, s_out_valid;
    logic [31:0] s_req_addr, s_out_pc, s_out_instr;
    logic [31:0] s_count;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int new_out();
        int n = 0;
        foreach (pend_ep[i]) if (pend_ep[i] == epoch) n++;
        return n;
    endfunction

    function automatic int old_out();
        int n = 0;
        foreach (pend_ep[i]) if (pend_ep[i] != epoch) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic cycle();
        logic        rsp_v, exp_rv, do_pop;
        logic [31:0] ra;
        int          re;
        rsp_v = (pend_due.size() > 0) && (pend_due[0] <= cyc);
        reset          = drv_reset;
        redirect       = drv_redirect;
        redirect_pc    = drv_rpc;
        out_ready      = drv_oready;
        imem_req_ready = drv_rready;
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_v ? instr_of(pend_addr[0]) : 32'hDEAD_BEEF;
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        s_count     = 32'(count);
        exp_rv = !drv_reset && !drv_redirect && (mq_pc.size() + new_out() < DEPTH)
                 && (new_out() < MAX_OUT);
        if (started) begin
            check("req_valid", s_req_valid, exp_rv);
            if (exp_rv) check("req_addr", s_req_addr, m_fetch_pc);
            check("out_valid", s_out_valid, mq_pc.size() != 0);
            check("count", s_count, mq_pc.size());
            check("squash_state", dbg_state, old_out() > 0);
            if (mq_pc.size() != 0) begin
                check("out_pc", s_out_pc, mq_pc[0]);
                check("out_instr", s_out_instr, mq_in[0]);
                m_last_pc = mq_pc[0];
                m_last_in = mq_in[0];
            end else begin
                check("hold_pc", s_out_pc, m_last_pc);
                check("hold_instr", s_out_instr, m_last_in);
            end
        end
        if (drv_reset) begin
            mq_pc.delete(); mq_in.delete();
            pend_addr.delete(); pend_ep.delete(); pend_due.delete();
            m_fetch_pc = RESET_PC;
            m_last_pc  = 32'h0;
            m_last_in  = 32'h0;
            epoch++;
            started = 1'b1;
        end else begin
            do_pop = drv_oready && (mq_pc.size() != 0) && !drv_redirect;
            if (do_pop) begin
                void'(mq_pc.pop_front());
                void'(mq_in.pop_front());
            end
            if (rsp_v) begin
                ra = pend_addr.pop_front();
                re = pend_ep.pop_front();
                void'(pend_due.pop_front());
                if (re == epoch && !drv_redirect) begin
                    mq_pc.push_back(ra);
                    mq_in.push_back(instr_of(ra));
                end
            end
            if (exp_rv && drv_rready) begin
                pend_addr.push_back(m_fetch_pc);
                pend_ep.push_back(epoch);
                pend_due.push_back(cyc + lat);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (drv_redirect) begin
                mq_pc.delete();
                mq_in.delete();
                m_fetch_pc = drv_rpc & ~32'h3;
                epoch++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_out_valid) found = 1'b1;
        end
        check(name, found, 1'b1);
    endtask

    task automatic wait_new_out2(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (new_out() == 2) found = 1'b1;
            else cycle();
        end
        check(name, found, 1'b1);
    endtask

    logic [7:0] or_pat = 8'b1011_0110;
    logic [4:0] rr_pat = 5'b11011;

    initial begin
        @(negedge clk);
        // reset
        drv_reset = 1'b1;
        cycle();
        cycle();
        check("rst_out_valid", s_out_valid, 1'b0);
        check("rst_count", s_count, 0);
        check("rst_req_valid", s_req_valid, 1'b0);
        check("rst_out_pc", s_out_pc, 32'h0);
        check("rst_out_instr", s_out_instr, 32'h0);

        // 1: 1-cycle imem, decode always ready
        drv_reset = 1'b0; drv_oready = 1'b1; drv_rready = 1'b1; lat = 1;
        cycle();
        check("t1_req0_valid", s_req_valid, 1'b1);
        check("t1_req0_addr", s_req_addr, 32'h0);
        cycle();
        check("t1_c1_out_valid", s_out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t1_out_valid", s_out_valid, 1'b1);
            check("t1_out_pc", s_out_pc, 32'(i * 4));
        end

        // 2: decode stalled, queue fills, then drains without gaps
        drv_oready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("t2_count_full", s_count, 4);
        check("t2_req_blocked", s_req_valid, 1'b0);
        check("t2_head_pc", s_out_pc, 32'h10);
        drv_oready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t2_valid", s_out_valid, 1'b1);
            check("t2_pc", s_out_pc, 32'(16 + 4 * i));
        end

        // 3: 3-cycle imem, redirect with two requests in flight
        lat = 3;
        for (int i = 0; i < 4; i++) cycle();
        wait_new_out2("t3_setup");
        drv_redirect = 1'b1; drv_rpc = 32'h40;
        cycle();
        drv_redirect = 1'b0;
        cycle();
        check("t3_flush_valid", s_out_valid, 1'b0);
        check("t3_flush_count", s_count, 0);
        check("t3_new_req", s_req_addr, 32'h40);
        wait_valid("t3_wait");
        check("t3_pc0", s_out_pc, 32'h40);
        cycle();
        check("t3_pc1", s_out_pc, 32'h44);

        // 3b: second redirect while the first squash is still draining
        wait_new_out2("t3b_setup");
        drv_redirect = 1'b1; drv_rpc = 32'h80;
        cycle();
        drv_redirect = 1'b0;
        cycle();
        drv_redirect = 1'b1; drv_rpc = 32'hC0;
        cycle();
        drv_redirect = 1'b0;
        wait_valid("t3b_wait");
        check("t3b_pc0", s_out_pc, 32'hC0);
        cycle();
        check("t3b_pc1", s_out_pc, 32'hC4);

        // 4: redirect coincides with a response and a pop
        lat = 1;
        for (int i = 0; i < 6; i++) cycle();
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                if (pend_due.size() > 0 && pend_due[0] <= cyc && mq_pc.size() > 0) ok = 1'b1;
                else cycle();
            end
            check("t4_setup", ok, 1'b1);
        end
        drv_redirect = 1'b1; drv_rpc = 32'h100;
        cycle();
        check("t4_pre_valid", s_out_valid, 1'b1);
        drv_redirect = 1'b0;
        cycle();
        check("t4_count", s_count, 0);
        check("t4_valid", s_out_valid, 1'b0);

        // 5: unaligned target near the top of the address space
        for (int i = 0; i < 4; i++) cycle();
        drv_redirect = 1'b1; drv_rpc = 32'hFFFF_FFFE;
        cycle();
        drv_redirect = 1'b0;
        cycle();
        check("t5_req0_valid", s_req_valid, 1'b1);
        check("t5_req0_addr", s_req_addr, 32'hFFFF_FFFC);
        cycle();
        check("t5_req1_addr", s_req_addr, 32'h0);
        wait_valid("t5_wait");
        check("t5_pc0", s_out_pc, 32'hFFFF_FFFC);
        cycle();
        check("t5_pc1", s_out_pc, 32'h0);

        // 6: reset mid-stream with two requests outstanding
        lat = 3;
        wait_new_out2("t6_setup");
        drv_reset = 1'b1;
        cycle();
        drv_reset = 1'b0;
        cycle();
        check("t6_out_valid", s_out_valid, 1'b0);
        check("t6_count", s_count, 0);
        check("t6_req_valid", s_req_valid, 1'b1);
        check("t6_req_addr", s_req_addr, RESET_PC);

        // 7: mixed back-pressure on both sides with a redirect in the middle
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            drv_oready   = or_pat[i % 8];
            drv_rready   = rr_pat[i % 5];
            drv_redirect = (i == 20);
            drv_rpc      = 32'h200;
            cycle();
        end
        drv_redirect = 1'b0; drv_oready = 1'b1; drv_rready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
